// File: rtl/pcm_stereo_buffer.sv
// pcm_stereo_buffer
//   Stereo frame FIFO in front of the I2S controller. Whole {left,right}
//   frames are pushed upstream; they are offered downstream one channel at a
//   time, always left then right, on a per-channel valid/ready handshake.
//   The block also reports fill level and counts underflows.
//
// Ports
//   sys_clk, sys_reset_n      clock, async active-low reset
//   in_left/in_right/in_valid frame push; in_ready = FIFO not full
//   flush                     synchronous discard of all stored frames
//   pcm_data                  sample of the channel currently offered
//   pcm_data_valid[1:0]       bit1 = left offered, bit0 = right offered
//   pcm_data_ready[1:0]       bit1 = left taken,   bit0 = right taken
//   fill_level                frames stored (0..DEPTH)
//   underflow_count/_clear    saturating underflow count and its clear
module pcm_stereo_buffer #(
  parameter int BIT_DEPTH       = 24,
  parameter int DEPTH           = 32,
  parameter int READY_EDGE      = 1,
  parameter int UNDERFLOW_WIDTH = 16
) (
  input  logic                       sys_clk,
  input  logic                       sys_reset_n,
  input  logic [BIT_DEPTH-1:0]       in_left,
  input  logic [BIT_DEPTH-1:0]       in_right,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  output logic [BIT_DEPTH-1:0]       pcm_data,
  output logic [1:0]                 pcm_data_valid,
  input  logic [1:0]                 pcm_data_ready,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic [UNDERFLOW_WIDTH-1:0] underflow_count,
  input  logic                       underflow_clear
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {ST_LEFT = 1'b0, ST_RIGHT = 1'b1} state_t;

  logic [BIT_DEPTH-1:0]       mem_l_q [DEPTH];
  logic [BIT_DEPTH-1:0]       mem_r_q [DEPTH];
  logic [AW-1:0]              wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]              count_q, count_d;
  state_t                     state_q, state_d;
  logic [1:0]                 rdy_q;
  logic [UNDERFLOW_WIDTH-1:0] uf_q, uf_d;

  logic       empty, full, push, pop, uf_inc;
  logic [1:0] eff;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign push  = in_valid & ~full & ~flush;

  // In edge mode the controller holds ready for a whole sclk period, so only
  // the first cycle of a high level counts as a take.
  assign eff = (READY_EDGE != 0) ? (pcm_data_ready & ~rdy_q) : pcm_data_ready;

  // Channel sequencer. Outputs depend only on registered state; ready only
  // steers the next state and the pop.
  always_comb begin
    state_d        = state_q;
    pop            = 1'b0;
    uf_inc         = 1'b0;
    pcm_data_valid = 2'b00;
    pcm_data       = '0;
    case (state_q)
      ST_LEFT: begin
        if (!empty) begin
          pcm_data_valid = 2'b10;
          pcm_data       = mem_l_q[rd_ptr_q];
          if (eff[1]) state_d = ST_RIGHT;
        end else begin
          uf_inc = eff[1];
        end
      end
      ST_RIGHT: begin
        // Head is only popped after right is taken, so it is never empty here.
        pcm_data_valid = 2'b01;
        pcm_data       = mem_r_q[rd_ptr_q];
        if (eff[0]) begin
          pop     = 1'b1;
          state_d = ST_LEFT;
        end
      end
      default: state_d = ST_LEFT;
    endcase
    if (flush) begin
      pop     = 1'b0;
      state_d = ST_LEFT;
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_comb begin
    uf_d = uf_q;
    if (underflow_clear)                              uf_d = '0;
    else if (uf_inc && uf_q != {UNDERFLOW_WIDTH{1'b1}}) uf_d = uf_q + 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_LEFT;
      rdy_q    <= 2'b00;
      uf_q     <= '0;
    end else begin
      rdy_q   <= pcm_data_ready;
      uf_q    <= uf_d;
      state_q <= state_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        count_q <= count_d;
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Sample storage carries no reset; unoccupied entries are never offered.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem_l_q[wr_ptr_q] <= in_left;
      mem_r_q[wr_ptr_q] <= in_right;
    end
  end

  assign in_ready        = ~full;
  assign fill_level      = count_q;
  assign underflow_count = uf_q;

endmodule

// File: tb/tb_pcm_stereo_buffer.sv
module tb_pcm_stereo_buffer;
  localparam int BD = 24;
  localparam int DP = 32;
  localparam int UW = 16;

  logic          sys_clk = 0;
  logic          sys_reset_n = 0;
  logic [BD-1:0] in_left = '0, in_right = '0;
  logic          in_valid = 0, flush = 0, underflow_clear = 0;
  logic          in_ready;
  logic [BD-1:0] pcm_data;
  logic [1:0]    pcm_data_valid;
  logic [1:0]    pcm_data_ready = 2'b00;
  logic [5:0]    fill_level;
  logic [UW-1:0] underflow_count;

  pcm_stereo_buffer #(.BIT_DEPTH(BD), .DEPTH(DP), .READY_EDGE(1), .UNDERFLOW_WIDTH(UW)) dut (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n),
    .in_left(in_left), .in_right(in_right), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .pcm_data(pcm_data), .pcm_data_valid(pcm_data_valid),
    .pcm_data_ready(pcm_data_ready), .fill_level(fill_level),
    .underflow_count(underflow_count), .underflow_clear(underflow_clear));

  always #5 sys_clk = ~sys_clk;

  typedef struct { logic left; logic [BD-1:0] d; } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  // Push a frame; the expected left/right transfers go to the scoreboard
  // only if the bench expects the push to be accepted.
  task automatic push_frame(input logic [BD-1:0] l, input logic [BD-1:0] r, input bit accept);
    in_left = l; in_right = r; in_valid = 1;
    tick();
    in_valid = 0;
    if (accept) begin
      sb.push_back('{1'b1, l});
      sb.push_back('{1'b0, r});
    end
  endtask

  task automatic pulse(input int ch, input int width);
    pcm_data_ready[ch] = 1'b1;
    tick(width);
    pcm_data_ready[ch] = 1'b0;
    tick();
  endtask

  // Monitor: a channel transfer happens at the coming edge when that channel
  // is offered and its ready rises. Each transfer pops and compares.
  logic [1:0] prev_rdy = 2'b00;
  always @(negedge sys_clk) begin
    exp_t e;
    if (!sys_reset_n) prev_rdy = 2'b00;
    else begin
      if (!flush) begin
        for (int c = 1; c >= 0; c--) begin
          if (pcm_data_valid[c] && pcm_data_ready[c] && !prev_rdy[c]) begin
            if (sb.size() == 0) begin
              n_chk++; n_fail++;
              $display("FAIL sb_underrun: unexpected transfer ch=%0d data=0x%0h at %0t", c, pcm_data, $time);
            end else begin
              e = sb.pop_front();
              check("xfer_chan", 32'(c), e.left ? 32'd1 : 32'd0);
              check("xfer_data", 32'(pcm_data), 32'(e.d));
            end
          end
        end
      end
      prev_rdy = pcm_data_ready;
    end
  end

  task automatic basic_scenario();
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_valid", 32'(pcm_data_valid), 0);
    check("rst_data", 32'(pcm_data), 0);
    check("rst_fill", 32'(fill_level), 0);
    check("rst_uf", 32'(underflow_count), 0);
    push_frame(24'h000001, 24'h800001, 1);
    check("s1_fill1", 32'(fill_level), 1);
    check("s1_valid_l", 32'(pcm_data_valid), 2);
    check("s1_data_l", 32'(pcm_data), 32'h000001);
    push_frame(24'h000002, 24'h800002, 1);
    check("s1_fill2", 32'(fill_level), 2);
    pulse(1, 8);
    check("s1_valid_r", 32'(pcm_data_valid), 1);
    check("s1_data_r", 32'(pcm_data), 32'h800001);
    check("s1_fill2b", 32'(fill_level), 2);
    pulse(0, 8);
    check("s1_fill_1", 32'(fill_level), 1);
    check("s1_data_l2", 32'(pcm_data), 32'h000002);
    pulse(1, 8);
    check("s1_data_r2", 32'(pcm_data), 32'h800002);
    pulse(0, 8);
    check("s1_fill_0", 32'(fill_level), 0);
    check("s1_valid_0", 32'(pcm_data_valid), 0);
    check("s1_data_0", 32'(pcm_data), 0);
    check("s1_sb_empty", 32'(sb.size()), 0);
  endtask

  initial begin
    #23 sys_reset_n = 1;
    tick();

    // Basic ordering and one transfer per held-ready pulse.
    basic_scenario();

    // Fill to full across the pointer wrap, drop the 33rd push, drain.
    for (int i = 0; i < DP; i++)
      push_frame(24'h000100 + 24'(i), 24'h800100 + 24'(i), 1);
    check("s2_full_ready", 32'(in_ready), 0);
    check("s2_full_fill", 32'(fill_level), 32);
    push_frame(24'h0BAD00, 24'h8BAD00, 0);
    check("s2_drop_fill", 32'(fill_level), 32);
    for (int i = 0; i < DP; i++) begin
      pulse(1, 2);
      pulse(0, 2);
    end
    check("s2_drained", 32'(fill_level), 0);
    check("s2_ready", 32'(in_ready), 1);
    check("s2_sb_empty", 32'(sb.size()), 0);

    // Underflow counting and clear priority.
    for (int i = 0; i < 3; i++) pulse(1, 2);
    check("s3_uf3", 32'(underflow_count), 3);
    check("s3_valid", 32'(pcm_data_valid), 0);
    pcm_data_ready[1] = 1; underflow_clear = 1;
    tick();
    underflow_clear = 0;
    tick();
    pcm_data_ready[1] = 0;
    tick();
    check("s3_uf_clr", 32'(underflow_count), 0);

    // Right-ready while offering left is ignored.
    push_frame(24'h000011, 24'h800011, 1);
    pulse(0, 2);
    check("s4_valid", 32'(pcm_data_valid), 2);
    check("s4_fill", 32'(fill_level), 1);
    check("s4_data", 32'(pcm_data), 32'h000011);

    // Flush in state RIGHT with coincident push and right-ready edge.
    for (int i = 2; i <= 5; i++) push_frame(24'h000010 + 24'(i), 24'h800010 + 24'(i), 1);
    check("s5_fill5", 32'(fill_level), 5);
    pulse(1, 2);
    check("s5_right", 32'(pcm_data_valid), 1);
    check("s5_rdata", 32'(pcm_data), 32'h800011);
    in_left = 24'h0BAD01; in_right = 24'h8BAD01; in_valid = 1;
    flush = 1; pcm_data_ready[0] = 1;
    tick();
    in_valid = 0; flush = 0;
    sb.delete();
    check("s5_fill0", 32'(fill_level), 0);
    check("s5_valid0", 32'(pcm_data_valid), 0);
    check("s5_data0", 32'(pcm_data), 0);
    pcm_data_ready[0] = 0;
    tick();
    push_frame(24'h000021, 24'h800021, 1);
    check("s5_left_state", 32'(pcm_data_valid), 2);
    check("s5_new_head", 32'(pcm_data), 32'h000021);
    pulse(1, 2);
    pulse(0, 2);
    check("s5_drained", 32'(fill_level), 0);

    // Asynchronous reset while offering right.
    pulse(1, 2);
    check("s6_uf1", 32'(underflow_count), 1);
    push_frame(24'h000031, 24'h800031, 1);
    push_frame(24'h000032, 24'h800032, 1);
    pulse(1, 2);
    check("s6_right", 32'(pcm_data_valid), 1);
    @(posedge sys_clk); #2;
    sys_reset_n = 0;
    #1;
    check("s6_ar_ready", 32'(in_ready), 1);
    check("s6_ar_valid", 32'(pcm_data_valid), 0);
    check("s6_ar_data", 32'(pcm_data), 0);
    check("s6_ar_fill", 32'(fill_level), 0);
    check("s6_ar_uf", 32'(underflow_count), 0);
    sb.delete();
    @(posedge sys_clk); #3;
    sys_reset_n = 1;
    tick();
    basic_scenario();

    check("final_sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0t expected < 200000", $time);
    $fatal(1);
  end
endmodule
